gpi_event: RTL and testbench
============================

# gpi_event

General-purpose input slot core: samples a W-bit external port (switches, buttons), synchronizes and debounces every bit, and latches per-bit rising/falling-edge events. Sits on the MMIO slot bus beside the output slot core and presents a small register map plus a level interrupt to the processor.

## Interface
- W, 8, number of input bits (1..16)
- CNT_W, 16, width of the debounce tick divider
- DB_N, 4, consecutive stable ticks required to accept a new level (≥2)
- DIV_RST, 999, reset value of the divider register
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cs  in  1  slot chip select
- read  in  1  read strobe (no side effects)
- write  in  1  write strobe
- addr  in  5  register index
- wr_data  in  32  write data
- rd_data  out  32  read data
- din  in  W  external asynchronous inputs
- irq  out  1  registered level interrupt

## Operation
- Sync: din → s1 → s2, 2 FFs per bit; raw = s2.
- Tick: tick_cnt counts 0..div; tick high for one cycle when tick_cnt == div, then tick_cnt ← 0. div = 0 → tick every cycle. A write to div clears tick_cnt.
- Debounce per bit i with counter cnt[i] (clog2(DB_N) bits):
  - raw[i] == db[i] → cnt[i] ← 0 (every cycle, tick or not).
  - raw[i] != db[i] and tick → if cnt[i] == DB_N-1: db[i] ← raw[i], cnt[i] ← 0, update[i] = 1; else cnt[i] ← cnt[i]+1.
- Events: rise[i] set on update with raw[i]=1; fall[i] set on update with raw[i]=0. Sticky until cleared.
- Write-1-to-clear: write to addr 2/3 clears bits where wr_data[i]=1. Same-cycle set and clear on a bit → set wins.
- irq ← |((rise & rise_en) | (fall & fall_en)), registered.
- Register map (write effective when cs && write; rd_data combinational from addr, zero-extended, independent of cs/read):
  - 0: db (RO)
  - 1: raw (RO)
  - 2: rise (R/W1C)
  - 3: fall (R/W1C)
  - 4: div [CNT_W-1:0] (RW)
  - 5: rise_en (RW)
  - 6: fall_en (RW)
  - others: read 0, writes ignored.
- Writes to RO addresses have no effect.

## Timing
- Reset values: s1, s2, db, cnt, rise, fall, rise_en, fall_en, tick_cnt, irq = 0; div = DIV_RST; rd_data reflects these.
- din → raw: 2 edges.
- raw change → db/rise/fall: exactly DB_N ticks while raw stays different; with div=0 this is DB_N edges. din → db total 2+DB_N edges at div=0.
- db/event set → irq: +1 edge. Clearing the last enabled event → irq low 1 edge after the write edge.
- Glitch shorter than DB_N ticks: cnt returns to 0, no db change, no event.
- Pulses shorter than 1 clk may be missed; no requirement.
- Enable written while event already pending → irq rises on next edge.
- Reset mid-debounce: all state returns to reset values immediately; no event generated on release even if din ≠ 0 until debounced (din=1 held through reset → rise after 2+DB_N ticks post-release).
- Independent bits may update on the same tick; each sets its own flag.

## Test plan
- Reset with din=0x00 → rd addr0..3,5,6 = 0, addr4 = 999, irq=0.
- div=0, din 0x00→0x05 held → addr1=0x05 after 2 edges; addr0=0x05 and addr2=0x05 after 6 edges; addr3=0.
- div=0, din bit0 high for 3 cycles then low → addr0 and addr2 remain 0.
- div=3, din 0x00→0x80 → db update after 4 ticks = 16 cycles (+2 sync); tick spacing 4 cycles.
- rise_en=0x01, rise=0x05 → irq=1; write addr2 = 0x01 → irq=0 next edge, addr2=0x04; simultaneous new rise on bit0 during clear → bit0 stays 1.
- din 0xFF→0x00 after debounce, fall_en=0xFF → addr3=0xFF, irq=1; assert reset mid-debounce → all outputs to reset values next cycle.

Source files
------------

// File: rtl/gpi_event.sv
// gpi_event: general-purpose input slot core.
// Synchronizes, debounces and edge-detects W inputs; MMIO registers plus a level irq.
module gpi_event #(
    parameter int W       = 8,
    parameter int CNT_W   = 16,
    parameter int DB_N    = 4,
    parameter int DIV_RST = 999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             read,
    input  logic             write,
    input  logic [4:0]       addr,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    input  logic [W-1:0]     din,
    output logic             irq
);

    localparam int CW = $clog2(DB_N);
    localparam logic [CW-1:0] CNT_TOP = CW'(DB_N - 1);

    logic [W-1:0]          s1_q, s1_d;
    logic [W-1:0]          s2_q, s2_d;
    logic [W-1:0]          db_q, db_d;
    logic [W-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]          rise_q, rise_d;
    logic [W-1:0]          fall_q, fall_d;
    logic [W-1:0]          rise_en_q, rise_en_d;
    logic [W-1:0]          fall_en_q, fall_en_d;
    logic [CNT_W-1:0]      div_q, div_d;
    logic [CNT_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic                  irq_q, irq_d;

    logic [W-1:0]          raw;
    logic [W-1:0]          upd;
    logic [W-1:0]          clr_rise;
    logic [W-1:0]          clr_fall;
    logic                  tick;
    logic                  wr_en;
    logic                  unused_ok;

    assign raw       = s2_q;
    assign wr_en     = cs && write;
    assign tick      = (tick_cnt_q == div_q);
    assign irq       = irq_q;
    assign unused_ok = &{1'b0, read, wr_data[31:CNT_W]};

    // Two-flop synchronizer on the raw port.
    always_comb begin
        s1_d = din;
        s2_d = s1_q;
    end

    // Tick divider; a write to the divider restarts the count.
    always_comb begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
        if (tick)
            tick_cnt_d = '0;
        if (wr_en && addr == 5'd4)
            tick_cnt_d = '0;
    end

    // Per-bit debounce: a new level must hold for DB_N consecutive ticks.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        upd   = '0;
        for (int i = 0; i < W; i++) begin
            if (raw[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_TOP) begin
                    db_d[i]  = raw[i];
                    cnt_d[i] = '0;
                    upd[i]   = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Sticky edge flags with write-1-to-clear; a same-cycle set wins.
    always_comb begin
        clr_rise = '0;
        clr_fall = '0;
        if (wr_en && addr == 5'd2)
            clr_rise = wr_data[W-1:0];
        if (wr_en && addr == 5'd3)
            clr_fall = wr_data[W-1:0];
        rise_d = (rise_q & ~clr_rise) | (upd & raw);
        fall_d = (fall_q & ~clr_fall) | (upd & ~raw);
    end

    // Writable configuration registers.
    always_comb begin
        div_d     = div_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (wr_en) begin
            unique case (addr)
                5'd4:    div_d     = wr_data[CNT_W-1:0];
                5'd5:    rise_en_d = wr_data[W-1:0];
                5'd6:    fall_en_d = wr_data[W-1:0];
                default: ;
            endcase
        end
    end

    // Interrupt is the registered OR of enabled pending events.
    always_comb begin
        irq_d = |((rise_q & rise_en_q) | (fall_q & fall_en_q));
    end

    // Read mux, zero-extended, independent of cs/read.
    always_comb begin
        rd_data = '0;
        unique case (addr)
            5'd0:    rd_data = 32'(db_q);
            5'd1:    rd_data = 32'(raw);
            5'd2:    rd_data = 32'(rise_q);
            5'd3:    rd_data = 32'(fall_q);
            5'd4:    rd_data = 32'(div_q);
            5'd5:    rd_data = 32'(rise_en_q);
            5'd6:    rd_data = 32'(fall_en_q);
            default: rd_data = '0;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            db_q       <= '0;
            cnt_q      <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            div_q      <= CNT_W'(DIV_RST);
            tick_cnt_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            db_q       <= db_d;
            cnt_q      <= cnt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_gpi_event.sv
// tb_gpi_event: table vectors and hand sequences for gpi_event.
// Expected register reads go through a queue and are compared on drain.
module tb_gpi_event;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [7:0]  din;
    logic        irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  din;
        int          n;
        logic [4:0]  a;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] v;
    } rd_t;

    vec_t tbl[6];
    rd_t  sb[$];

    gpi_event #(
        .W(8), .CNT_W(16), .DB_N(4), .DIV_RST(999)
    ) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read),
        .write(write), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .din(din), .irq(irq)
    );

    always #10 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a,
                          input logic [31:0] e);
        addr = a;
        #1;
        chk($sformatf("%s[a%0d]", nm, a), rd_data, e);
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] v);
        rd_t r;
        r.a = a;
        r.v = v;
        sb.push_back(r);
    endtask

    task automatic drain(input string nm);
        rd_t r;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            rd_chk(nm, r.a, r.v);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
        cs      = 1'b0;
        write   = 1'b0;
        wr_data = '0;
    endtask

    initial begin
        tbl[0] = '{8'h05, 1, 5'd1, 32'h00};
        tbl[1] = '{8'h05, 1, 5'd1, 32'h05};
        tbl[2] = '{8'h05, 3, 5'd0, 32'h00};
        tbl[3] = '{8'h05, 1, 5'd0, 32'h05};
        tbl[4] = '{8'h05, 0, 5'd2, 32'h05};
        tbl[5] = '{8'h05, 0, 5'd3, 32'h00};

        reset   = 1'b1;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wr_data = '0;
        din     = '0;
        step(3);
        reset = 1'b0;

        for (int a = 0; a < 8; a++)
            push(5'(a), (a == 4) ? 32'd999 : 32'd0);
        drain("reset");
        chk("reset_irq", {31'b0, irq}, 0);

        // div=0, rising edges on bits 0 and 2
        wr(5'd4, 32'd0);
        for (int i = 0; i < 6; i++) begin
            din = tbl[i].din;
            step(tbl[i].n);
            push(tbl[i].a, tbl[i].exp);
            drain($sformatf("vec%0d", i));
        end

        // enable after pending event, then W1C
        wr(5'd5, 32'h01);
        chk("irq_en_same", {31'b0, irq}, 0);
        step(1);
        chk("irq_en_next", {31'b0, irq}, 1);
        wr(5'd2, 32'h01);
        chk("irq_clr_same", {31'b0, irq}, 1);
        step(1);
        chk("irq_clr_next", {31'b0, irq}, 0);
        rd_chk("w1c", 5'd2, 32'h04);

        // glitch of DB_N-1 cycles on bit1
        din = 8'h07;
        step(3);
        din = 8'h05;
        step(10);
        push(5'd0, 32'h05);
        push(5'd2, 32'h04);
        push(5'd3, 32'h00);
        drain("glitch");

        // pulse of exactly DB_N cycles on bit1
        din = 8'h07;
        step(4);
        din = 8'h05;
        step(12);
        push(5'd0, 32'h05);
        push(5'd2, 32'h06);
        push(5'd3, 32'h02);
        drain("pulse4");
        chk("pulse_irq", {31'b0, irq}, 0);

        // clear on the same edge bit3 rises: set wins
        din = 8'h0D;
        step(5);
        wr(5'd2, 32'h0C);
        push(5'd2, 32'h0A);
        push(5'd0, 32'h0D);
        drain("setwins");

        // fall interrupt
        wr(5'd6, 32'h02);
        chk("fall_irq_same", {31'b0, irq}, 0);
        step(1);
        chk("fall_irq_next", {31'b0, irq}, 1);
        wr(5'd3, 32'h02);
        step(1);
        chk("fall_irq_clr", {31'b0, irq}, 0);

        // div=3: update lands 16 edges after the write
        wr(5'd4, 32'd3);
        din = 8'h8D;
        step(15);
        rd_chk("div3_early", 5'd0, 32'h0D);
        step(1);
        rd_chk("div3_upd", 5'd0, 32'h8D);
        rd_chk("div3_rise", 5'd2, 32'h8A);

        // all bits fall
        wr(5'd4, 32'd0);
        din = 8'hFF;
        step(8);
        wr(5'd2, 32'hFF);
        wr(5'd3, 32'hFF);
        push(5'd0, 32'hFF);
        push(5'd2, 32'h00);
        push(5'd3, 32'h00);
        drain("allhi");
        din = 8'h00;
        step(8);
        push(5'd0, 32'h00);
        push(5'd3, 32'hFF);
        drain("allfall");
        wr(5'd6, 32'hFF);
        step(1);
        chk("allfall_irq", {31'b0, irq}, 1);

        // reset in the middle of a debounce
        din = 8'hFF;
        step(3);
        reset = 1'b1;
        #1;
        chk("rst_irq", {31'b0, irq}, 0);
        for (int a = 0; a < 8; a++)
            push(5'(a), (a == 4) ? 32'd999 : 32'd0);
        drain("midrst");
        step(2);
        reset = 1'b0;
        wr(5'd4, 32'd0);
        step(4);
        push(5'd0, 32'h00);
        push(5'd2, 32'h00);
        drain("post_early");
        step(1);
        push(5'd0, 32'hFF);
        push(5'd2, 32'hFF);
        push(5'd3, 32'h00);
        drain("post_upd");
        chk("post_irq", {31'b0, irq}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
